// File: rtl/spram_pkg.sv
// spram_pkg: shared types and constants for the SPRAM request/response front end.
//   size_e  : request size encoding as seen on req_size
//   state_e : controller FSM states
//   MASK_*  : SPRAM nibble write masks (bit n enables DI[4n+3:4n])
//   req_is_err : size/alignment legality check applied at accept time
package spram_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ACC0 = 3'd1,
        ACC1 = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4,
        STBY = 3'd5,
        WAKE = 3'd6
    } state_e;

    localparam logic [3:0] MASK_LO  = 4'b0011;
    localparam logic [3:0] MASK_HI  = 4'b1100;
    localparam logic [3:0] MASK_ALL = 4'b1111;

    // Illegal size, odd halfword, or word32 not on a 4-byte boundary.
    function automatic logic req_is_err(input size_e sz, input logic [1:0] a_lo);
        case (sz)
            SZ_HALF: return a_lo[0];
            SZ_WORD: return (a_lo != 2'b00);
            SZ_BAD:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/spram_ctrl.sv
// spram_ctrl: request/response front end for a 16K x 16 single-port SPRAM.
// Byte-addressed byte/half/word32 accesses become one or two 16-bit SPRAM
// cycles; read data returns with fixed latency; standby entry/exit handled.
// Ports:
//   clk, rst            clock (also clocks the SPRAM), async active-high reset
//   req_valid/ready     request handshake; req_we/size/addr/wdata captured on accept
//   rsp_valid/data/err  one-cycle response pulse, zero-extended read data, error flag
//   stdby_req           standby request
//   ram_ad/di/maskwe/we/cs/stdby, ram_do   SPRAM macro pins
module spram_ctrl
    import spram_pkg::*;
#(
    parameter int WAKE_CYCLES = 2,
    parameter int WK_W        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        stdby_req,
    output logic [13:0] ram_ad,
    output logic [15:0] ram_di,
    output logic [3:0]  ram_maskwe,
    output logic        ram_we,
    output logic        ram_cs,
    output logic        ram_stdby,
    input  logic [15:0] ram_do
);

    state_e            state_q, state_d;
    logic [14:0]       addr_q, addr_d;
    size_e             size_q, size_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [15:0]       lo_q, lo_d;
    logic [WK_W-1:0]   wk_cnt_q, wk_cnt_d;

    logic              in_acc;

    // Next-state and capture logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        wk_cnt_d = wk_cnt_q;
        case (state_q)
            IDLE: begin
                // Standby wins over a simultaneous request.
                if (stdby_req) begin
                    state_d = STBY;
                end else if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = size_e'(req_size);
                    we_d    = req_we;
                    wdata_d = req_wdata;
                    state_d = req_is_err(size_e'(req_size), req_addr[1:0]) ? ERR : ACC0;
                end
            end
            ACC0: state_d = (size_q == SZ_WORD) ? ACC1 : RESP;
            ACC1: begin
                // Low half read at the ACC0 edge is on ram_do now; the high
                // half will overwrite it at this edge.
                lo_d    = ram_do;
                state_d = RESP;
            end
            RESP, ERR: state_d = stdby_req ? STBY : IDLE;
            STBY: begin
                if (!stdby_req) begin
                    state_d  = WAKE;
                    wk_cnt_d = WK_W'(WAKE_CYCLES);
                end
            end
            WAKE: begin
                wk_cnt_d = wk_cnt_q - 1'b1;
                if (stdby_req)
                    state_d = STBY;
                else if (wk_cnt_q == WK_W'(1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= SZ_BYTE;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            lo_q     <= '0;
            wk_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            wk_cnt_q <= wk_cnt_d;
        end
    end

    // SPRAM pin decode; everything is zero outside the access states so an
    // async reset deasserts chip select within the same cycle.
    assign in_acc = (state_q == ACC0) || (state_q == ACC1);

    always_comb begin
        ram_cs     = in_acc;
        ram_we     = in_acc && we_q;
        ram_stdby  = (state_q == STBY);
        ram_ad     = '0;
        ram_di     = '0;
        ram_maskwe = '0;
        if (state_q == ACC0) begin
            ram_ad = addr_q[14:1];
            if (size_q == SZ_BYTE) begin
                ram_di = {wdata_q[7:0], wdata_q[7:0]};
                if (we_q)
                    ram_maskwe = addr_q[0] ? MASK_HI : MASK_LO;
            end else begin
                ram_di = wdata_q[15:0];
                if (we_q)
                    ram_maskwe = MASK_ALL;
            end
        end else if (state_q == ACC1) begin
            ram_ad = addr_q[14:1] + 14'd1;
            ram_di = wdata_q[31:16];
            if (we_q)
                ram_maskwe = MASK_ALL;
        end
    end

    // Response decode
    always_comb begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        if (state_q == RESP) begin
            rsp_valid = 1'b1;
            if (!we_q) begin
                case (size_q)
                    SZ_BYTE: rsp_data = {24'b0, addr_q[0] ? ram_do[15:8] : ram_do[7:0]};
                    SZ_HALF: rsp_data = {16'b0, ram_do};
                    SZ_WORD: rsp_data = {ram_do, lo_q};
                    default: rsp_data = '0;
                endcase
            end
        end else if (state_q == ERR) begin
            rsp_valid = 1'b1;
            rsp_err   = 1'b1;
        end
    end

    assign req_ready = (state_q == IDLE) && !stdby_req;

endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: self-checking bench for spram_ctrl with a behavioural 16K x 16
// SPRAM (nibble write mask, registered read data, SLEEP=0 and powered on).
// Expected values come from a byte-addressed little-endian reference memory.
module tb_spram_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [14:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        stdby_req = 1'b0;
    logic [13:0] ram_ad;
    logic [15:0] ram_di;
    logic [3:0]  ram_maskwe;
    logic        ram_we;
    logic        ram_cs;
    logic        ram_stdby;
    logic [15:0] ram_do;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    spram_ctrl #(.WAKE_CYCLES(2), .WK_W(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .stdby_req(stdby_req),
        .ram_ad(ram_ad), .ram_di(ram_di), .ram_maskwe(ram_maskwe),
        .ram_we(ram_we), .ram_cs(ram_cs), .ram_stdby(ram_stdby), .ram_do(ram_do)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SPRAM model
    logic [15:0] mem [0:16383];
    logic        mem_clr = 1'b1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 16'h0;
            ram_do <= 16'h0;
        end else if (ram_cs && !ram_stdby) begin
            if (ram_we) begin
                for (int n = 0; n < 4; n++)
                    if (ram_maskwe[n]) mem[ram_ad][n*4 +: 4] <= ram_di[n*4 +: 4];
            end else begin
                ram_do <= mem[ram_ad];
            end
        end
    end

    // Reference model: 32 KB of bytes, little-endian
    logic [7:0] ref_mem [0:32767];

    function automatic int nbytes(input int sz);
        return (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    endfunction

    function automatic void ref_write(input int sz, input int a, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) ref_mem[a + i] = wd[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_read(input int sz, input int a);
        logic [31:0] r = '0;
        for (int i = 0; i < nbytes(sz); i++) r[8*i +: 8] = ref_mem[a + i];
        return r;
    endfunction

    function automatic logic exp_err(input int sz, input int a);
        if (sz == 3) return 1'b1;
        if (sz == 1 && (a % 2) != 0) return 1'b1;
        if (sz == 2 && (a % 4) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Issues one request and records what the DUT did; lat = -1 on timeout.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic [14:0] a,
                          input logic [31:0] wd, output int lat, output logic [31:0] d,
                          output logic e, output logic [13:0] ad0, output logic [13:0] ad1,
                          output logic [3:0] m0, output logic [15:0] di0,
                          output int cs_cnt, output int acc);
        bit got_ready = 0;
        lat = -1; d = '0; e = 1'b0; ad0 = '0; ad1 = '0; m0 = '0; di0 = '0; cs_cnt = 0; acc = -1;
        for (int w = 0; w < 50; w++) begin
            @(negedge clk);
            if (req_ready) begin got_ready = 1; break; end
        end
        if (!got_ready) return;
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ram_cs) cs_cnt++;
            if (k == 1) begin ad0 = ram_ad; m0 = ram_maskwe; di0 = ram_di; end
            if (k == 2) ad1 = ram_ad;
            if (rsp_valid) begin lat = k; d = rsp_data; e = rsp_err; break; end
        end
    endtask

    task automatic test_reset();
        if ({rsp_valid, rsp_err, rsp_data, ram_ad, ram_di, ram_maskwe, ram_we, ram_cs, ram_stdby} !== '0) begin
            errors++; $display("FAIL reset_outputs got nonzero outputs rsp_data=%h ram_ad=%h", rsp_data, ram_ad);
        end
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++;
        stdby_req = 1'b1;
        #1;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_stdby got %b exp 0", req_ready); end
        checks++;
        stdby_req = 1'b0;
    endtask

    task automatic test_word_roundtrip();
        int lat, cs, acc; logic [31:0] d; logic e; logic [13:0] a0, a1; logic [3:0] m; logic [15:0] di;
        do_req(1'b1, 2'b10, 15'h0100, 32'h12345678, lat, d, e, a0, a1, m, di, cs, acc);
        ref_write(2, 'h100, 32'h12345678);
        checks++; if (lat != 3 || d !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL w32_write_rsp got lat=%0d d=%h e=%b exp lat=3 d=0 e=0", lat, d, e); end
        checks++; if (a0 !== 14'h080 || a1 !== 14'h081) begin errors++; $display("FAIL w32_write_ad got %h,%h exp 080,081", a0, a1); end
        checks++; if (m !== 4'hF || cs != 2) begin errors++; $display("FAIL w32_write_mask got m=%b cs=%0d exp 1111 2", m, cs); end
        do_req(1'b0, 2'b10, 15'h0100, 32'h0, lat, d, e, a0, a1, m, di, cs, acc);
        checks++; if (lat != 3 || d !== 32'h12345678) begin errors++; $display("FAIL w32_read got lat=%0d d=%h exp lat=3 d=12345678", lat, d); end
        checks++; if (a0 !== 14'h080 || a1 !== 14'h081 || m !== 4'h0) begin errors++; $display("FAIL w32_read_ad got %h,%h m=%b exp 080,081 0000", a0, a1, m); end
    endtask

    task automatic test_byte_merge();
        int lat, cs, acc; logic [31:0] d; logic e; logic [13:0] a0, a1; logic [3:0] m; logic [15:0] di;
        do_req(1'b1, 2'b01, 15'h0200, 32'h0000AAAA, lat, d, e, a0, a1, m, di, cs, acc);
        ref_write(1, 'h200, 32'h0000AAAA);
        do_req(1'b1, 2'b00, 15'h0201, 32'hFFFFFF5C, lat, d, e, a0, a1, m, di, cs, acc);
        ref_write(0, 'h201, 32'hFFFFFF5C);
        checks++; if (m !== 4'b1100 || di !== 16'h5C5C) begin errors++; $display("FAIL byte_write_pins got m=%b di=%h exp 1100 5c5c", m, di); end
        do_req(1'b0, 2'b01, 15'h0200, 32'h0, lat, d, e, a0, a1, m, di, cs, acc);
        checks++; if (lat != 2 || d !== 32'h00005CAA) begin errors++; $display("FAIL byte_merge_read got lat=%0d d=%h exp 2 00005caa", lat, d); end
    endtask

    task automatic test_misaligned();
        int lat, cs, acc; logic [31:0] d; logic e; logic [13:0] a0, a1; logic [3:0] m; logic [15:0] di;
        do_req(1'b0, 2'b01, 15'h0003, 32'h0, lat, d, e, a0, a1, m, di, cs, acc);
        checks++; if (lat != 1 || e !== 1'b1 || cs != 0 || d !== 32'h0) begin errors++; $display("FAIL misaligned_half got lat=%0d e=%b cs=%0d d=%h exp 1 1 0 0", lat, e, cs, d); end
        do_req(1'b1, 2'b10, 15'h0006, 32'hDEADBEEF, lat, d, e, a0, a1, m, di, cs, acc);
        checks++; if (lat != 1 || e !== 1'b1 || cs != 0 || d !== 32'h0) begin errors++; $display("FAIL misaligned_word got lat=%0d e=%b cs=%0d d=%h exp 1 1 0 0", lat, e, cs, d); end
    endtask

    task automatic test_standby();
        int wake = 0; int lat = -1; bit saw_rsp = 0; logic [31:0] d = '0;
        @(negedge clk);
        stdby_req = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_addr = 15'h0100;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stdby_prio_ready got %b exp 0", req_ready); end
        @(negedge clk);
        checks++; if (ram_stdby !== 1'b1 || req_ready !== 1'b0 || ram_cs !== 1'b0) begin errors++; $display("FAIL stdby_entry got stdby=%b ready=%b cs=%b exp 1 0 0", ram_stdby, req_ready, ram_cs); end
        repeat (3) begin @(negedge clk); if (rsp_valid) saw_rsp = 1; end
        stdby_req = 1'b0;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1;
            if (req_ready) break;
            wake++;
        end
        checks++; if (wake != 2) begin errors++; $display("FAIL wake_cycles got %0d exp 2", wake); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (rsp_valid) begin lat = k; d = rsp_data; break; end
        end
        checks++; if (saw_rsp || lat != 2 || d !== {24'h0, ref_mem['h100]}) begin errors++; $display("FAIL stdby_then_read got early=%0d lat=%0d d=%h exp 0 2 %h", saw_rsp, lat, d, ref_mem['h100]); end
    endtask

    task automatic test_reset_mid();
        int lat, cs, acc; int rsp_seen = 0; logic [31:0] d; logic e; logic [13:0] a0, a1; logic [3:0] m; logic [15:0] di;
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 15'h0010; req_wdata = 32'hCAFEBABE;
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);            // ACC0
        @(negedge clk);            // ACC1, its write edge still ahead
        checks++; if (ram_cs !== 1'b1 || ram_ad !== 14'h009) begin errors++; $display("FAIL acc1_before_reset got cs=%b ad=%h exp 1 009", ram_cs, ram_ad); end
        rst = 1'b1;
        #1;
        checks++; if (ram_cs !== 1'b0 || ram_we !== 1'b0 || ram_maskwe !== 4'h0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_pins got cs=%b we=%b m=%b rsp=%b exp 0 0 0 0", ram_cs, ram_we, ram_maskwe, rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin @(negedge clk); if (rsp_valid) rsp_seen++; end
        checks++; if (rsp_seen != 0) begin errors++; $display("FAIL reset_mid_rsp got %0d responses exp 0", rsp_seen); end
        ref_write(1, 'h10, 32'hCAFEBABE);   // only the ACC0 half reached the macro
        do_req(1'b0, 2'b10, 15'h0010, 32'h0, lat, d, e, a0, a1, m, di, cs, acc);
        checks++; if (lat != 3 || d !== ref_read(2, 'h10)) begin errors++; $display("FAIL reset_mid_read got lat=%0d d=%h exp 3 %h", lat, d, ref_read(2, 'h10)); end
    endtask

    task automatic test_top_boundary();
        int lat, cs, acc; logic [31:0] d; logic e; logic [13:0] a0, a1; logic [3:0] m; logic [15:0] di;
        do_req(1'b1, 2'b00, 15'h7FFF, 32'h000000EE, lat, d, e, a0, a1, m, di, cs, acc);
        ref_write(0, 'h7FFF, 32'hEE);
        checks++; if (a0 !== 14'h3FFF || m !== 4'b1100 || lat != 2) begin errors++; $display("FAIL top_write got ad=%h m=%b lat=%0d exp 3fff 1100 2", a0, m, lat); end
        do_req(1'b0, 2'b00, 15'h7FFF, 32'h0, lat, d, e, a0, a1, m, di, cs, acc);
        checks++; if (d !== 32'h000000EE || lat != 2) begin errors++; $display("FAIL top_read got d=%h lat=%0d exp 000000ee 2", d, lat); end
    endtask

    task automatic test_back_to_back();
        int lat, cs, acc1, acc2; logic [31:0] d; logic e; logic [13:0] a0, a1; logic [3:0] m; logic [15:0] di;
        do_req(1'b0, 2'b01, 15'h0200, 32'h0, lat, d, e, a0, a1, m, di, cs, acc1);
        do_req(1'b0, 2'b01, 15'h0200, 32'h0, lat, d, e, a0, a1, m, di, cs, acc2);
        checks++; if (acc2 - acc1 != 3) begin errors++; $display("FAIL b2b_half got spacing %0d exp 3", acc2 - acc1); end
        do_req(1'b0, 2'b10, 15'h0100, 32'h0, lat, d, e, a0, a1, m, di, cs, acc1);
        do_req(1'b0, 2'b10, 15'h0100, 32'h0, lat, d, e, a0, a1, m, di, cs, acc2);
        checks++; if (acc2 - acc1 != 4) begin errors++; $display("FAIL b2b_word got spacing %0d exp 4", acc2 - acc1); end
    endtask

    task automatic test_random();
        int lat, cs, acc, sz, a, r, xlat; logic [31:0] d, wd, xd; logic e, we, xe; logic [13:0] a0, a1; logic [3:0] m, xm; logic [15:0] di;
        for (int it = 0; it < 300; it++) begin
            r  = $urandom_range(0, 9);
            sz = (r < 3) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
            a  = ($urandom_range(0, 1) != 0 ? 'h7FC0 : 'h0040) + $urandom_range(0, 63);
            if ($urandom_range(0, 3) != 0 && sz != 3) a = a & ~(nbytes(sz) - 1);
            we = 1'($urandom_range(0, 1));
            wd = $urandom;
            xe   = exp_err(sz, a);
            xlat = xe ? 1 : (sz == 2) ? 3 : 2;
            xd   = (xe || we) ? 32'h0 : ref_read(sz, a);
            xm   = (xe || !we) ? 4'h0 : (sz != 0) ? 4'hF : ((a % 2) != 0) ? 4'b1100 : 4'b0011;
            do_req(we, 2'(sz), 15'(a), wd, lat, d, e, a0, a1, m, di, cs, acc);
            if (!xe && we) ref_write(sz, a, wd);
            checks++;
            if (lat != xlat || e !== xe || d !== xd || m !== xm) begin
                errors++;
                $display("FAIL random[%0d] we=%0d sz=%0d a=%h got lat=%0d e=%b d=%h m=%b exp lat=%0d e=%b d=%h m=%b",
                         it, we, sz, a, lat, e, d, m, xlat, xe, xd, xm);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ref_mem[i] = 8'h0;
        repeat (2) @(negedge clk);
        mem_clr = 1'b0;
        test_reset();
        @(negedge clk);
        rst = 1'b0;
        test_word_roundtrip();
        test_byte_merge();
        test_misaligned();
        test_standby();
        test_reset_mid();
        test_top_boundary();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spram_ctrl.md
Name: spram_ctrl

Overview:
- Request/response front end for one 16K x 16 single-port SPRAM macro; sits directly upstream of it and drives its AD/DI/MASKWE/WE/CS/STDBY pins.
- Converts byte-addressed CPU/bus accesses (byte, half, 32-bit word) into 16-bit SPRAM cycles. 32-bit accesses take two cycles.
- Returns read data with fixed latency and manages standby entry and exit.
- SLEEP and PWROFF_N are tied off at top level and are not handled here.

Parameters:
- WAKE_CYCLES, 2, idle cycles after standby exit before req_ready may rise (must be >= 1).
- WK_W, 4, width of the wake counter (must satisfy 2^WK_W > WAKE_CYCLES).

Ports:
- clk  in  1  single clock; also clocks the SPRAM.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a clock edge where req_valid and req_ready are both high.
- req_we  in  1  1 = write, 0 = read.
- req_size  in  2  00 = byte, 01 = half, 10 = word32, 11 = illegal.
- req_addr  in  15  byte address, 32 KB space, little-endian.
- req_wdata  in  32  write data, right-justified.
- rsp_valid  out  1  one-cycle response pulse, issued for reads and writes.
- rsp_data  out  32  read data, zero-extended; 0 when !rsp_valid or for writes.
- rsp_err  out  1  qualifies rsp_valid: misaligned or illegal request.
- stdby_req  in  1  standby request.
- ram_ad  out  14  SPRAM word address.
- ram_di  out  16  SPRAM write data.
- ram_maskwe  out  4  SPRAM nibble write mask.
- ram_we  out  1  SPRAM write enable.
- ram_cs  out  1  SPRAM chip select.
- ram_stdby  out  1  SPRAM standby.
- ram_do  in  16  SPRAM read data.

Behaviour:
- States: IDLE, ACC0, ACC1, RESP, ERR, STBY, WAKE.
- Reset: async to IDLE, word counter 0, internal regs 0. Every output is 0 in reset except req_ready, which is 1 when !stdby_req.
- Reset mid-access: ram_cs drops immediately. A write whose SPRAM edge has not yet occurred is not performed. No rsp_valid is issued.
- req_ready = (state==IDLE) && !stdby_req.
- Accept: captures addr, size, we and wdata.
  - Legal request -> ACC0.
  - Error request -> ERR. An error is size 11, a half at addr[0]=1, or a word32 with addr[1:0]!=0.
- Cycle numbering: accept cycle = C0.
  - byte/half: C1 = ACC0, C2 = RESP.
  - word32: C1 = ACC0, C2 = ACC1, C3 = RESP.
  - error: C1 = ERR.
- ram_* outputs are decoded combinationally from state and captured regs. ram_cs=1 only in ACC0 and ACC1.
- ACC0 address and data:
  - ram_ad = addr[14:1].
  - ram_di: byte -> {b,b}; half -> wdata[15:0]; word32 -> wdata[15:0].
- ACC0 write mask: byte at even address -> 0011; byte at odd address -> 1100; half and word32 -> 1111.
- ACC1: ram_ad = addr[14:1]+1, ram_di = wdata[31:16], mask 1111. At the ACC1->RESP edge, ram_do (low half) is registered into lo_q.
- ram_we = req_we in ACC0/ACC1. ram_maskwe = 0 on reads and outside access states.
- RESP: rsp_valid=1, rsp_err=0. Read data:
  - byte: {24'b0, addr[0] ? ram_do[15:8] : ram_do[7:0]}.
  - half: {16'b0, ram_do}.
  - word32: {ram_do, lo_q}.
  - writes: rsp_data = 0, never X.
- ERR: rsp_valid=1, rsp_err=1, rsp_data=0, no SPRAM access.
- Next state after RESP or ERR:
  - stdby_req=1 -> STBY.
  - otherwise -> IDLE.
  - Peak throughput is one request per 3 cycles (16-bit) or 4 cycles (word32).
- Standby priority and timing:
  - In IDLE, stdby_req has priority over a simultaneous req_valid: no accept, go to STBY.
  - stdby_req rising mid-access lets the access complete first.
- STBY: ram_stdby=1, ram_cs=0. When stdby_req falls -> WAKE with counter loaded to WAKE_CYCLES.
- WAKE: ram_stdby=0, counter decrements, -> IDLE when it reaches 1. stdby_req re-asserted during WAKE -> STBY.

Decomposition:
- spram_pkg holds:
  - size enum SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD;
  - state enum;
  - mask constants MASK_LO=4'b0011, MASK_HI=4'b1100, MASK_ALL=4'b1111.
- No sub-module: single FSM plus datapath.
- The bench instantiates spram_ctrl with the SP256K model and ties SLEEP=0. PWROFF_N is tied to the value that keeps the model's "off" term low.

Test Plan:
- Word32 round trip: write word32 0x12345678 at 0x0100, then read word32 at 0x0100. Write is acked at C3 with rsp_data=0; read returns 0x12345678 at C3; ram_ad = 0x080 then 0x081.
- Byte merge: half write 0xAAAA at 0x0200, byte write 0x5C at 0x0201, half read at 0x0200. The byte write drives mask 1100 and di 0x5C5C; the read returns 0x00005CAA at C2.
- Misaligned: half read at 0x0003, then word32 write at 0x0006. Each gives rsp_valid=1, rsp_err=1 at C1, with ram_cs never asserted.
- Standby vs request: stdby_req and req_valid both rise in IDLE. req_ready=0 and ram_stdby=1 next cycle. Drop stdby_req: exactly WAKE_CYCLES=2 cycles of WAKE, then req_ready=1 and the request is accepted.
- Async reset during ACC1 of a word32 write at 0x0010: outputs clear immediately and no rsp_valid is issued. A read of 0x0010 after reset shows the low half written and the high half unchanged.
- Top word boundary: byte write 0xEE at 0x7FFF, then byte read at 0x7FFF. ram_ad=0x3FFF, mask 1100, read returns 0x000000EE.
